// File: rtl/qspi_mem_model.sv
// QSPI memory emulator: NUM_CS byte-addressed banks behind one shared quad bus,
// decoding quad read (0x0B) and quad write (0x02), with backdoor preload and a sticky error flag.
module qspi_mem_model #(
  parameter int                NUM_CS        = 3,
  parameter int                DEPTH_LOG2    = 12,
  parameter int                DUMMY_NIBBLES = 4,
  parameter logic [NUM_CS-1:0] RO_MASK       = 3'b001,
  localparam int               SEL_W         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic [NUM_CS-1:0]     spi_cs_n,
  input  logic [3:0]            spi_data_in,
  output logic [3:0]            spi_data_out,
  output logic [3:0]            spi_data_oe,
  input  logic                  bd_we,
  input  logic [SEL_W-1:0]      bd_sel,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [7:0]            bd_data,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam int         CNT_W     = 8;
  localparam logic [CNT_W-1:0] LAST_DUMMY =
    CNT_W'((DUMMY_NIBBLES > 0) ? DUMMY_NIBBLES - 1 : 0);

  state_t           state, state_n;
  logic             sck_q, sck_qq;
  logic [3:0]       din_q;
  logic             rise, fall, stay;
  logic [CNT_W-1:0] nib_cnt;
  logic [3:0]       cmd_hi;
  logic [7:0]       cmd_word;
  logic [23:0]      addr;
  logic             is_read;
  logic             phase;
  logic [3:0]       wr_hi;
  logic [SEL_W-1:0] bank, sel_idx;
  int               n_low;
  logic             multi_sel, cmd_bad, spi_we;
  logic [7:0]       rd_byte;

  logic [7:0] mem [NUM_CS][DEPTH];

  assign rise      = sck_q & ~sck_qq;
  assign fall      = ~sck_q & sck_qq;
  assign cmd_word  = {cmd_hi, din_q};
  assign multi_sel = (n_low > 1);
  assign stay      = (state_n == state);
  assign busy      = (state != S_IDLE);
  assign rd_byte   = mem[bank][addr[DEPTH_LOG2-1:0]];
  assign spi_we    = (state == S_WRITE) && rise && phase && stay && !RO_MASK[bank];

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    n_low   = 0;
    sel_idx = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!spi_cs_n[i]) begin
        n_low   = n_low + 1;
        sel_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    cmd_bad = 1'b0;
    if (state == S_IDLE) begin
      if (n_low > 1)       state_n = S_IGNORE;
      else if (n_low == 1) state_n = S_CMD;
    end else if (multi_sel) begin
      state_n = S_IGNORE;
    end else if (state == S_IGNORE) begin
      if (&spi_cs_n) state_n = S_IDLE;
    end else if (spi_cs_n[bank]) begin
      state_n = S_IDLE;
    end else if (rise) begin
      case (state)
        S_CMD: begin
          if (nib_cnt == CNT_W'(1)) begin
            if (cmd_word == CMD_READ || cmd_word == CMD_WRITE) begin
              state_n = S_ADDR;
            end else begin
              state_n = S_IGNORE;
              cmd_bad = 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (nib_cnt == CNT_W'(5)) begin
            if (!is_read)                state_n = S_WRITE;
            else if (DUMMY_NIBBLES == 0) state_n = S_READ;
            else                         state_n = S_DUMMY;
          end
        end
        S_DUMMY: if (nib_cnt == LAST_DUMMY) state_n = S_READ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q        <= 1'b0;
      sck_qq       <= 1'b0;
      din_q        <= '0;
      err          <= 1'b0;
      bank         <= '0;
      nib_cnt      <= '0;
      phase        <= 1'b0;
      cmd_hi       <= '0;
      is_read      <= 1'b0;
      addr         <= '0;
      wr_hi        <= '0;
      spi_data_out <= '0;
      spi_data_oe  <= '0;
    end else begin
      sck_q  <= spi_clk;
      sck_qq <= sck_q;
      din_q  <= spi_data_in;
      err    <= err | multi_sel | cmd_bad;

      if (state == S_IDLE && n_low == 1) bank <= sel_idx;

      if (!stay)     nib_cnt <= '0;
      else if (rise) nib_cnt <= nib_cnt + 1'b1;

      if (rise && state == S_CMD) begin
        cmd_hi <= din_q;
        if (nib_cnt == CNT_W'(1)) is_read <= (cmd_word == CMD_READ);
      end
      if (rise && state == S_ADDR) addr <= {addr[19:0], din_q};

      // Data phases toggle between high and low nibble; the address moves after the low one.
      if (!stay) begin
        phase <= 1'b0;
      end else if ((state == S_WRITE && rise) || (state == S_READ && fall)) begin
        phase <= ~phase;
        if (phase) addr <= addr + 24'd1;
        if (!phase && state == S_WRITE) wr_hi <= din_q;
      end

      if (state_n != S_READ) begin
        spi_data_out <= '0;
        spi_data_oe  <= '0;
      end else if (state == S_READ && fall) begin
        spi_data_out <= phase ? rd_byte[3:0] : rd_byte[7:4];
        spi_data_oe  <= 4'hF;
      end
    end
  end

  // NOTE: storage is left out of the reset so contents survive rst_n and map onto RAM.
  // The backdoor write comes last so it wins a collision on the same byte.
  always_ff @(posedge clk) begin
    if (spi_we) mem[bank][addr[DEPTH_LOG2-1:0]] <= {wr_hi, din_q};
    if (bd_we && (int'(bd_sel) < NUM_CS)) mem[bd_sel][bd_addr] <= bd_data;
  end

endmodule
